tk_sync_4ph_responder: RTL and testbench

//  Clocked responder for a Teak 4-phase bundled-data push channel.
//  - Asynchronous Teak logic drives req/data.
//  - This block synchronises req, captures data, and returns ack using the return-to-zero protocol.
//  - Captured words are buffered and presented as a valid/ready stream to synchronous logic.
//  - It is the synchronous receiving end of channels built from the async gate library (C-elements, mutex).

---
 rtl/tk_sync_4ph_responder_if.sv | 26 ++
 rtl/tk_sync_4ph_responder.sv | 150 +++++++++++++++
 tb/tb_tk_sync_4ph_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tk_sync_4ph_responder_if.sv
// Signal bundle for the Teak 4-phase push channel and the clocked valid/ready output stream.
// slave = the responder; master = async environment plus downstream consumer.
interface tk_sync_4ph_responder_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             a_req;
    logic [WIDTH-1:0] a_data;
    logic             a_ack;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_ready;
    logic [CW-1:0]    o_count;

    modport slave (
        input  a_req, a_data, o_ready,
        output a_ack, o_valid, o_data, o_count
    );

    modport master (
        output a_req, a_data, o_ready,
        input  a_ack, o_valid, o_data, o_count
    );
endinterface

// File: rtl/tk_sync_4ph_responder.sv
// Clocked 4-phase bundled-data responder: synchronises a_req, captures a_data into a FIFO,
// returns a_ack (return-to-zero). Optional statistics ports under macro TK_RESP_STATS_EN.
// Output stream: o_valid/o_data are a registered view; a word transfers on any rising edge
// where o_valid & o_ready, and o_valid/o_data may only change after such a transfer or a push.
module tk_sync_4ph_responder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    tk_sync_4ph_responder_if.slave  bus,
`ifdef TK_RESP_STATS_EN
    output logic [15:0]             stat_tokens,
    output logic                    stat_stall,
`endif
    output logic [1:0]              o_dbg_state
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_ACKED = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic               w_req_s;
    logic               r_ack;
    logic               w_ack_next;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      w_rd_next;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_avail;
    logic               r_valid;
    logic [WIDTH-1:0]   r_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], bus.a_req};
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];
    // Fullness uses the start-of-cycle count, so a simultaneous pop never admits a push.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = r_valid & bus.o_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ack_next   = r_ack;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_s) begin
                    if (!w_full) begin
                        w_push       = 1'b1;
                        w_ack_next   = 1'b1;
                        w_state_next = ST_ACKED;
                    end else begin
                        w_state_next = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (!w_full) begin
                    w_push       = 1'b1;
                    w_ack_next   = 1'b1;
                    w_state_next = ST_ACKED;
                end
            end
            ST_ACKED: begin
                if (!w_req_s) begin
                    w_ack_next   = 1'b0;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_ack_next   = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wr_ptr] <= bus.a_data;
    end

    // A freshly pushed word only becomes visible at the head one cycle after its push.
    assign w_avail   = r_count - CW'(w_pop);
    assign w_rd_next = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            r_rd_ptr <= w_rd_next;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_valid  <= (w_avail != '0);
            if (w_avail != '0) r_data <= r_mem[w_rd_next];
        end
    end

`ifdef TK_RESP_STATS_EN
    logic w_stall_entry;
    assign w_stall_entry = (r_state != ST_STALL) && (w_state_next == ST_STALL);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_tokens <= '0;
            stat_stall  <= 1'b0;
        end else begin
            if (w_push)        stat_tokens <= stat_tokens + 16'd1;
            if (w_stall_entry) stat_stall  <= 1'b1;
        end
    end
`endif

    assign bus.a_ack   = r_ack;
    assign bus.o_valid = r_valid;
    assign bus.o_data  = r_data;
    assign bus.o_count = r_count;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_tk_sync_4ph_responder.sv
// Directed bench for tk_sync_4ph_responder: DEPTH=2 instance for handshake/stall/reset cases,
// DEPTH=3 instance for a long token run with a randomised consumer.
module tb_tk_sync_4ph_responder;
    logic clk;
    logic reset;
    logic [1:0] dbg2;
    logic [1:0] dbg3;
    int   checks;
    int   failures;
    bit   rand_en;
    logic [7:0] exp2_q[$];
    logic [7:0] exp3_q[$];

    tk_sync_4ph_responder_if #(.WIDTH(8), .DEPTH(2)) bus2 ();
    tk_sync_4ph_responder_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

`ifdef TK_RESP_STATS_EN
    logic [15:0] st2_tok;
    logic [15:0] st3_tok;
    logic        st2_stall;
    logic        st3_stall;
`endif

    tk_sync_4ph_responder #(.WIDTH(8), .SYNC_STAGES(2), .DEPTH(2)) u_dut2 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus2),
`ifdef TK_RESP_STATS_EN
        .stat_tokens (st2_tok),
        .stat_stall  (st2_stall),
`endif
        .o_dbg_state (dbg2)
    );

    tk_sync_4ph_responder #(.WIDTH(8), .SYNC_STAGES(2), .DEPTH(3)) u_dut3 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus3),
`ifdef TK_RESP_STATS_EN
        .stat_tokens (st3_tok),
        .stat_stall  (st3_stall),
`endif
        .o_dbg_state (dbg3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input bit sel, input logic level, input string tag);
        logic cur;
        cur = sel ? bus3.a_ack : bus2.a_ack;
        for (int n = 0; n < 64 && cur !== level; n++) begin
            tick(1);
            cur = sel ? bus3.a_ack : bus2.a_ack;
        end
        check(tag, 32'(cur), 32'(level));
    endtask

    // driver: one full 4-phase token on the DEPTH=2 channel
    task automatic send2(input logic [7:0] d);
        check("send2_ack_idle", 32'(bus2.a_ack), 32'd0);
        bus2.a_data = d;
        exp2_q.push_back(d);
        bus2.a_req = 1'b1;
        wait_ack(1'b0, 1'b1, "send2_ack_rise");
        bus2.a_req = 1'b0;
        wait_ack(1'b0, 1'b0, "send2_ack_fall");
    endtask

    // randomised consumer on the DEPTH=3 channel
    initial begin
        bus3.o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus3.o_ready = rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // scoreboards: each accepted head word must be the oldest outstanding token
    always @(negedge clk) begin
        if (!reset) begin
            check("cnt2_bound", 32'(bus2.o_count <= 2'd2), 32'd1);
            if (bus2.o_valid && bus2.o_ready) begin
                checks++;
                assert (exp2_q.size() > 0) else begin
                    failures++;
                    $error("FAIL out2_extra observed=0x%0h expected=none", bus2.o_data);
                end
                if (exp2_q.size() > 0) check("out2_data", 32'(bus2.o_data), 32'(exp2_q.pop_front()));
            end
            check("cnt3_bound", 32'(bus3.o_count <= 2'd3), 32'd1);
            if (bus3.o_valid && bus3.o_ready) begin
                checks++;
                assert (exp3_q.size() > 0) else begin
                    failures++;
                    $error("FAIL out3_extra observed=0x%0h expected=none", bus3.o_data);
                end
                if (exp3_q.size() > 0) check("out3_data", 32'(bus3.o_data), 32'(exp3_q.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] d;
        checks   = 0;
        failures = 0;
        rand_en  = 1'b0;
        reset    = 1'b1;
        bus2.a_req   = 1'b0;
        bus2.a_data  = 8'h00;
        bus2.o_ready = 1'b1;
        bus3.a_req   = 1'b0;
        bus3.a_data  = 8'h00;
        tick(3);
        check("rst_ack",   32'(bus2.a_ack),   32'd0);
        check("rst_valid", 32'(bus2.o_valid), 32'd0);
        check("rst_data",  32'(bus2.o_data),  32'd0);
        check("rst_count", 32'(bus2.o_count), 32'd0);
        reset = 1'b0;
        tick(2);

        // 1: single token, latency of ack rise/fall and head visibility
        bus2.a_data = 8'h5A;
        exp2_q.push_back(8'h5A);
        bus2.a_req = 1'b1;
        tick(2);
        check("t1_ack_early", 32'(bus2.a_ack), 32'd0);
        tick(1);
        check("t1_ack_rise",  32'(bus2.a_ack),   32'd1);
        check("t1_count",     32'(bus2.o_count), 32'd1);
        check("t1_valid_lag", 32'(bus2.o_valid), 32'd0);
        tick(1);
        check("t1_valid",     32'(bus2.o_valid), 32'd1);
        check("t1_data",      32'(bus2.o_data),  32'h5A);
        bus2.a_req = 1'b0;
        tick(2);
        check("t1_ack_hold",  32'(bus2.a_ack),   32'd1);
        tick(1);
        check("t1_ack_fall",  32'(bus2.a_ack),   32'd0);
        check("t1_count0",    32'(bus2.o_count), 32'd0);

        // 2: backpressure fills the FIFO, third token stalls
        bus2.o_ready = 1'b0;
        send2(8'h11);
        send2(8'h22);
        check("t2_count2", 32'(bus2.o_count), 32'd2);
        check("t2_valid",  32'(bus2.o_valid), 32'd1);
        check("t2_head",   32'(bus2.o_data),  32'h11);
        bus2.a_data = 8'h33;
        exp2_q.push_back(8'h33);
        bus2.a_req = 1'b1;
        tick(6);
        check("t2_stall_ack",   32'(bus2.a_ack),   32'd0);
        check("t2_stall_count", 32'(bus2.o_count), 32'd2);
        check("t2_stall_state", 32'(dbg2),         32'd1);
        bus2.o_ready = 1'b1;
        tick(1);
        check("t2_pop_ack",   32'(bus2.a_ack),   32'd0);
        check("t2_pop_count", 32'(bus2.o_count), 32'd1);
        tick(1);
        check("t2_push_ack",   32'(bus2.a_ack),   32'd1);
        check("t2_push_count", 32'(bus2.o_count), 32'd1);
        bus2.a_req = 1'b0;
        wait_ack(1'b0, 1'b0, "t2_ack_fall");
        tick(4);
        check("t2_drain_count", 32'(bus2.o_count), 32'd0);
        check("t2_drain_q",     32'(exp2_q.size()), 32'd0);
`ifdef TK_RESP_STATS_EN
        check("t2_stat_stall", 32'(st2_stall), 32'd1);
`endif

        // 3: full FIFO with a pop in the cycle req_s is first seen
        bus2.o_ready = 1'b0;
        send2(8'hA1);
        send2(8'hA2);
        check("t3_full", 32'(bus2.o_count), 32'd2);
        bus2.a_data = 8'hA3;
        exp2_q.push_back(8'hA3);
        bus2.a_req = 1'b1;
        tick(2);
        bus2.o_ready = 1'b1;
        tick(1);
        check("t3_no_push_ack",   32'(bus2.a_ack),   32'd0);
        check("t3_no_push_count", 32'(bus2.o_count), 32'd1);
        tick(1);
        check("t3_push_ack",   32'(bus2.a_ack),   32'd1);
        check("t3_push_count", 32'(bus2.o_count), 32'd1);
        bus2.a_req = 1'b0;
        wait_ack(1'b0, 1'b0, "t3_ack_fall");
        tick(4);
        check("t3_drain_q", 32'(exp2_q.size()), 32'd0);

        // 4: reset mid-handshake, still-high a_req is a fresh token
        bus2.o_ready = 1'b0;
        bus2.a_data = 8'h77;
        bus2.a_req = 1'b1;
        wait_ack(1'b0, 1'b1, "t4_ack");
        check("t4_count_pre", 32'(bus2.o_count), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t4_rst_ack",   32'(bus2.a_ack),   32'd0);
        check("t4_rst_valid", 32'(bus2.o_valid), 32'd0);
        check("t4_rst_count", 32'(bus2.o_count), 32'd0);
        exp2_q.delete();
        exp2_q.push_back(8'h77);
        tick(2);
        check("t4_retoken_early", 32'(bus2.a_ack), 32'd0);
        tick(1);
        check("t4_retoken_ack",   32'(bus2.a_ack),   32'd1);
        check("t4_retoken_count", 32'(bus2.o_count), 32'd1);
        bus2.o_ready = 1'b1;
        bus2.a_req = 1'b0;
        wait_ack(1'b0, 1'b0, "t4_ack_fall");
        tick(4);
        check("t4_drain_q", 32'(exp2_q.size()), 32'd0);
`ifdef TK_RESP_STATS_EN
        check("t4_stat_tokens", 32'(st2_tok),   32'd1);
        check("t4_stat_stall",  32'(st2_stall), 32'd0);
`endif

        // 5: 300 back-to-back tokens into DEPTH=3 with a random consumer
        rand_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom_range(0, 255));
            check("t5_ack_idle", 32'(bus3.a_ack), 32'd0);
            bus3.a_data = d;
            exp3_q.push_back(d);
            bus3.a_req = 1'b1;
            wait_ack(1'b1, 1'b1, "t5_ack_rise");
            bus3.a_req = 1'b0;
            wait_ack(1'b1, 1'b0, "t5_ack_fall");
        end
        rand_en = 1'b0;
        for (int n = 0; n < 32 && exp3_q.size() != 0; n++) tick(1);
        tick(2);
        check("t5_drain_q",     32'(exp3_q.size()), 32'd0);
        check("t5_drain_count", 32'(bus3.o_count),  32'd0);
        check("t5_state_idle",  32'(dbg3),          32'd0);
`ifdef TK_RESP_STATS_EN
        check("t5_stat_tokens", 32'(st3_tok), 32'd300);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
